// File: rtl/dsp_mac_seq_pkg.sv
// dsp_pkg: constants and types shared by the dsp_mac_seq slice.
//   OPM_*   : DSP48A1 OPMODE values driven toward the external slice
//   *_LAG   : cycles from beat acceptance to OPMODE / CEP / P use
//   state_e : sequencer FSM states
//   tag_t   : per-beat tag travelling alongside the DSP pipeline
//   sat_p   : clamp a 48-bit signed P to a signed w-bit range
package dsp_pkg;

    localparam logic [7:0] OPM_ZERO = 8'h00;  // X=0, Z=0
    localparam logic [7:0] OPM_MUL  = 8'h01;  // P = M
    localparam logic [7:0] OPM_MAC  = 8'h09;  // P = P + M

    // A0 -> A1 -> M -> P register chain inside the DSP48A1
    localparam int OPM_LAG = 2;
    localparam int CEP_LAG = 3;
    localparam int P_LAG   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_HOLD
    } state_e;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    function automatic logic [47:0] sat_p(input logic [47:0] p, input int w);
        logic signed [47:0] ps, hi, lo;
        ps = signed'(p);
        hi = (48'sd1 <<< (w - 1)) - 48'sd1;
        lo = ~hi;
        if (ps > hi)      return hi;
        else if (ps < lo) return lo;
        else              return p;
    endfunction

endpackage

// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq_if: control, operand-beat and result handshake bundle.
//   start_i/len_i/busy_o        : job control
//   a_i/b_i/valid_i/ready_o     : operand beats
//   res_o/res_valid_o/res_ready_i : result handshake
// Modports: master = job source/result sink, slave = dsp_mac_seq.
interface dsp_mac_seq_if #(
    parameter int LEN_W = 8,
    parameter int RES_W = 32
);
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic [17:0]      a_i;
    logic [17:0]      b_i;
    logic             valid_i;
    logic             ready_o;
    logic [RES_W-1:0] res_o;
    logic             res_valid_o;
    logic             res_ready_i;

    modport master (
        output start_i, len_i, a_i, b_i, valid_i, res_ready_i,
        input  busy_o, ready_o, res_o, res_valid_o
    );

    modport slave (
        input  start_i, len_i, a_i, b_i, valid_i, res_ready_i,
        output busy_o, ready_o, res_o, res_valid_o
    );
endinterface

// File: rtl/dsp_mac_seq_tag_pipe.sv
// dsp_tag_pipe: shift register of beat tags that mirrors the DSP48A1
// register chain, so control arrives at the slice in step with its data.
//   clk_i, rst_ni      : clock, async active-low reset (clears all tags)
//   tag_i              : tag of the beat accepted this cycle
//   tap_opm_o/cep_o/p_o: tag delayed by OPM_LAG / CEP_LAG / P_LAG cycles
module dsp_tag_pipe
    import dsp_pkg::*;
#(
    parameter int DEPTH = P_LAG
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  tag_t tag_i,
    output tag_t tap_opm_o,
    output tag_t tap_cep_o,
    output tag_t tap_p_o
);

    tag_t [DEPTH:1] vld_pipe;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= tag_i;
            for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign tap_opm_o = vld_pipe[OPM_LAG];
    assign tap_cep_o = vld_pipe[CEP_LAG];
    assign tap_p_o   = vld_pipe[P_LAG];

endmodule

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: sequences an external DSP48A1 (A0/A1/B0/B1/M/P/OPMODE
// registers enabled) through a signed 18x18 dot product of len_i beats.
//   clk_i, rst_ni   : clock, async active-low reset
//   bus (slave)     : start/len/busy, a/b beat handshake, result handshake
//   dsp_a_o/dsp_b_o : operands, straight from a_i/b_i
//   dsp_opmode_o    : MUL for the first beat, MAC after, ZERO on bubbles
//   dsp_cep_o       : P clock enable, only for real beats
//   dsp_p_i         : 48-bit P from the slice
// Build option: define DSP_MAC_SEQ_SAT_EN to saturate P into RES_W bits
// instead of truncating.
module dsp_mac_seq
    import dsp_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int RES_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    dsp_mac_seq_if.slave  bus,
    output logic [17:0]   dsp_a_o,
    output logic [17:0]   dsp_b_o,
    output logic [7:0]    dsp_opmode_o,
    output logic          dsp_cep_o,
    input  logic [47:0]   dsp_p_i
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q;
    logic             first_q;
    logic [RES_W-1:0] res_q, res_next;
    logic             accept, last_beat, res_cap;
    tag_t             tag_in, tap_opm, tap_cep, tap_p;

    assign accept    = bus.valid_i && (state_q == S_ISSUE);
    assign last_beat = (cnt_q == LEN_W'(1));
    assign res_cap   = tap_p.valid && tap_p.last;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = (bus.len_i == '0) ? S_HOLD : S_ISSUE;
            S_ISSUE: if (accept && last_beat) state_d = S_DRAIN;
            S_DRAIN: if (res_cap) state_d = S_HOLD;
            S_HOLD:  if (bus.res_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.busy_o      = (state_q != S_IDLE);
        bus.ready_o     = (state_q == S_ISSUE);
        bus.res_valid_o = (state_q == S_HOLD);
    end

    // Beat counter and first-beat flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else if (state_q == S_IDLE && bus.start_i) begin
            cnt_q   <= bus.len_i;
            first_q <= 1'b1;
        end else if (accept) begin
            cnt_q   <= cnt_q - LEN_W'(1);
            first_q <= 1'b0;
        end
    end

    assign tag_in = '{valid: accept, first: first_q, last: accept && last_beat};

    dsp_tag_pipe #(.DEPTH(P_LAG)) u_tag_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .tag_i     (tag_in),
        .tap_opm_o (tap_opm),
        .tap_cep_o (tap_cep),
        .tap_p_o   (tap_p)
    );

    assign dsp_a_o   = bus.a_i;
    assign dsp_b_o   = bus.b_i;
    assign dsp_cep_o = tap_cep.valid;

    // The first beat uses Z=0, so whatever P held before (including
    // a run cut short by reset) never reaches the new sum.
    always_comb begin
        dsp_opmode_o = OPM_ZERO;
        if (tap_opm.valid) dsp_opmode_o = tap_opm.first ? OPM_MUL : OPM_MAC;
    end

`ifdef DSP_MAC_SEQ_SAT_EN
    logic [47:0] p_sat;
    assign p_sat    = sat_p(dsp_p_i, RES_W);
    assign res_next = p_sat[RES_W-1:0];
`else
    assign res_next = dsp_p_i[RES_W-1:0];
`endif

    // Cleared on start so a zero-length job reports 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                             res_q <= '0;
        else if (state_q == S_IDLE && bus.start_i) res_q <= '0;
        else if (res_cap)                        res_q <= res_next;
    end

    assign bus.res_o = res_q;

    logic unused_bits;
    assign unused_bits = ^{dsp_p_i, tap_opm.last, tap_cep.first, tap_cep.last, tap_p.first};

endmodule
